// File: rtl/texture_block_fetch.sv
// texture_block_fetch
// Fetches one 4x4 RGB565 texel block (16 words) from texture memory as a
// single 16-beat burst and presents it as a 256-bit block word together with
// the tag of the request that produced it. One block in flight at a time;
// the assembled block is held until the consumer accepts it.
module texture_block_fetch #(
    parameter int ADDR_W = 24,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              block_valid,
    input  logic              block_ready,
    output logic [255:0]      block_data,
    output logic [TAG_W-1:0]  block_tag,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [3:0]        cnt_reg;
    logic [15:0]       texel_reg [16];

    logic accept;
    logic beat;
    logic last_beat;

    // The block base is always 16-word aligned, so the low address bits of
    // the request carry no information and are dropped here.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[3:0]};

    assign accept    = (state_reg == IDLE) && req_valid;
    // Beats only count while collecting; anything arriving elsewhere is stray.
    assign beat      = (state_reg == COLLECT) && mem_rvalid;
    assign last_beat = beat && (cnt_reg == 4'd15);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (block_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture aligned base address and tag when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg <= '0;
            tag_reg  <= '0;
        end else if (accept) begin
            base_reg <= {req_addr[ADDR_W-1:4], 4'b0000};
            tag_reg  <= req_tag;
        end
    end

    // Beat counter: cleared when the burst is granted, steps per valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 4'd0;
        end else if ((state_reg == ISSUE) && mem_ack) begin
            cnt_reg <= 4'd0;
        end else if (beat) begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    // One 16-bit lane register per texel; lane gi loads on the beat whose
    // count matches its index, so the block assembles in row-major order.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            // Load texel gi from its beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    texel_reg[gi] <= 16'h0000;
                end else if (beat && (cnt_reg == 4'(gi))) begin
                    texel_reg[gi] <= mem_rdata;
                end
            end

            assign block_data[16*gi +: 16] = texel_reg[gi];
        end
    endgenerate

    // All handshake outputs decode directly from the state register, so no
    // input reaches an output combinationally.
    assign req_ready   = (state_reg == IDLE);
    assign mem_req     = (state_reg == ISSUE);
    assign mem_addr    = base_reg;
    assign block_valid = (state_reg == DONE);
    assign block_tag   = tag_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_texture_block_fetch.sv
// Directed testbench for texture_block_fetch: reset, basic fetch latency,
// stalls, stray inputs, mid-burst reset and back-to-back requests.
module tb_texture_block_fetch;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [23:0]  req_addr;
    logic [7:0]   req_tag;
    logic         mem_req;
    logic [23:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [15:0]  mem_rdata;
    logic         block_valid;
    logic         block_ready;
    logic [255:0] block_data;
    logic [7:0]   block_tag;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    texture_block_fetch #(.ADDR_W(24), .TAG_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_tag     (req_tag),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
        .block_tag   (block_tag),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string name, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Expected block: texel i = base + i
    function automatic logic [255:0] make_blk(input logic [15:0] base);
        logic [255:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            b[16*i +: 16] = base + 16'(i);
        end
        return b;
    endfunction

    task automatic send_beat(input logic [15:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
    endtask

    task automatic pulse_ack();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    int           gaps [16] = '{0, 1, 3, 2, 0, 0, 1, 3, 2, 1, 0, 3, 0, 2, 1, 0};
    logic [255:0] held;
    logic         rv_ok;
    logic         ra_ok;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_tag     = '0;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        block_ready = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        chk_bit ("rst_req_ready",   req_ready,   1'b1);
        chk_bit ("rst_mem_req",     mem_req,     1'b0);
        chk_word("rst_mem_addr",    32'(mem_addr), 32'h0);
        chk_bit ("rst_block_valid", block_valid, 1'b0);
        chk_blk ("rst_block_data",  block_data,  256'h0);
        chk_word("rst_block_tag",   32'(block_tag), 32'h0);
        chk_bit ("rst_busy",        busy,        1'b0);
        rst_n = 1'b1;
        tick();
        chk_bit ("rel_req_ready",   req_ready,   1'b1);
        chk_bit ("rel_busy",        busy,        1'b0);

        // ---------------- basic fetch ----------------
        req_valid = 1'b1;
        req_addr  = 24'h001237;
        req_tag   = 8'h5A;
        tick();                                   // accept edge (cycle T)
        req_valid = 1'b0;
        chk_bit ("basic_mem_req_t1",  mem_req, 1'b1);
        chk_word("basic_mem_addr",    32'(mem_addr), 32'h001230);
        chk_bit ("basic_busy",        busy, 1'b1);
        chk_bit ("basic_req_ready",   req_ready, 1'b0);
        pulse_ack();                              // now T+2
        chk_bit ("basic_mem_req_drop", mem_req, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                chk_bit("basic_valid_early", block_valid, 1'b0);
            end
            send_beat(16'h1000 + 16'(i), 0);
        end
        chk_bit ("basic_valid_t18", block_valid, 1'b1);
        chk_blk ("basic_data",      block_data, make_blk(16'h1000));
        chk_word("basic_tag",       32'(block_tag), 32'h5A);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk_bit ("basic_handoff_valid", block_valid, 1'b0);
        chk_bit ("basic_handoff_ready", req_ready, 1'b1);

        // ---------------- stray beat in IDLE ----------------
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        chk_blk ("idle_stray_data", block_data, make_blk(16'h1000));
        chk_bit ("idle_stray_busy", busy, 1'b0);

        // ---------------- stalls + stray inputs ----------------
        req_valid = 1'b1;
        req_addr  = 24'h04567F;
        req_tag   = 8'hA7;
        tick();
        req_valid = 1'b0;
        req_addr  = 24'hFFFFFF;
        // ack held off 5 cycles with a stray beat in ISSUE
        rv_ok = 1'b1;
        ra_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (!(mem_req === 1'b1)) rv_ok = 1'b0;
            if (!(mem_addr === 24'h045670)) ra_ok = 1'b0;
            mem_rvalid = (c == 2);
            mem_rdata  = 16'hDEAD;
            tick();
        end
        mem_rvalid = 1'b0;
        chk_bit ("stall_mem_req_steady",  rv_ok, 1'b1);
        chk_bit ("stall_mem_addr_steady", ra_ok, 1'b1);
        chk_bit ("stall_still_issue",     mem_req, 1'b1);
        pulse_ack();
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                // extra ack mid-burst must not reset the count
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
            end
            send_beat(16'h2000 + 16'(i), gaps[i]);
        end
        chk_bit ("stall_valid", block_valid, 1'b1);
        chk_blk ("stall_data",  block_data, make_blk(16'h2000));
        chk_word("stall_tag",   32'(block_tag), 32'hA7);
        held = block_data;
        // consumer stalls 10 cycles; a stray beat arrives in DONE
        rv_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mem_rvalid = (c == 4);
            mem_rdata  = 16'hDEAD;
            tick();
            if (!(block_valid === 1'b1) || !(req_ready === 1'b0) || !(block_tag === 8'hA7))
                rv_ok = 1'b0;
        end
        mem_rvalid = 1'b0;
        chk_bit ("done_stall_hold", rv_ok, 1'b1);
        chk_blk ("done_stray_data", block_data, held);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk_bit ("stall_handoff", req_ready, 1'b1);

        // ---------------- reset mid-burst ----------------
        req_valid = 1'b1;
        req_addr  = 24'h00ABCD;
        req_tag   = 8'h33;
        tick();
        req_valid = 1'b0;
        chk_word("mid_mem_addr", 32'(mem_addr), 32'h00ABC0);
        pulse_ack();
        for (int i = 0; i < 8; i++) begin
            send_beat(16'h3000 + 16'(i), 0);
        end
        rst_n = 1'b0;
        #2;
        chk_bit ("mid_rst_req_ready", req_ready, 1'b1);
        chk_blk ("mid_rst_data",      block_data, 256'h0);
        chk_word("mid_rst_mem_addr",  32'(mem_addr), 32'h0);
        chk_bit ("mid_rst_busy",      busy, 1'b0);
        rst_n = 1'b1;
        tick();
        for (int i = 8; i < 16; i++) begin
            send_beat(16'h3000 + 16'(i), 0);
        end
        chk_bit ("mid_late_valid", block_valid, 1'b0);
        chk_bit ("mid_late_busy",  busy, 1'b0);
        chk_blk ("mid_late_data",  block_data, 256'h0);
        req_valid = 1'b1;
        req_addr  = 24'h00FF0F;
        req_tag   = 8'hC3;
        tick();
        req_valid = 1'b0;
        chk_word("fresh_mem_addr", 32'(mem_addr), 32'h00FF00);
        pulse_ack();
        for (int i = 0; i < 16; i++) begin
            send_beat(16'h4000 + 16'(i), 0);
        end
        chk_bit ("fresh_valid", block_valid, 1'b1);
        chk_blk ("fresh_data",  block_data, make_blk(16'h4000));
        chk_word("fresh_tag",   32'(block_tag), 32'hC3);
        block_ready = 1'b1;
        tick();

        // ---------------- back-to-back ----------------
        // block_ready stays high from here on
        req_valid = 1'b1;
        req_addr  = 24'h100050;
        req_tag   = 8'h11;
        tick();
        req_addr  = 24'h200060;
        req_tag   = 8'h22;
        chk_bit ("b2b_busy_blocks", req_ready, 1'b0);
        pulse_ack();
        for (int i = 0; i < 16; i++) begin
            send_beat(16'h5000 + 16'(i), 0);
        end
        // cycle D
        chk_bit ("b2b_first_valid", block_valid, 1'b1);
        chk_blk ("b2b_first_data",  block_data, make_blk(16'h5000));
        chk_word("b2b_first_tag",   32'(block_tag), 32'h11);
        tick();                                   // D+1
        chk_bit ("b2b_d1_valid",    block_valid, 1'b0);
        chk_bit ("b2b_d1_ready",    req_ready, 1'b1);
        chk_bit ("b2b_d1_mem_req",  mem_req, 1'b0);
        tick();                                   // D+2
        req_valid = 1'b0;
        chk_bit ("b2b_d2_mem_req",  mem_req, 1'b1);
        chk_word("b2b_d2_mem_addr", 32'(mem_addr), 32'h200060);
        pulse_ack();
        for (int i = 0; i < 16; i++) begin
            send_beat(16'h6000 + 16'(i), 0);
        end
        chk_bit ("b2b_second_valid", block_valid, 1'b1);
        chk_blk ("b2b_second_data",  block_data, make_blk(16'h6000));
        chk_word("b2b_second_tag",   32'(block_tag), 32'h22);
        tick();
        chk_bit ("b2b_end_idle", busy, 1'b0);
        block_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
